// File: rtl/p_i_cache_line_fill.sv
// p_i_cache_line_fill: memory-side responder for I-cache line misses.
// Takes a line request, fetches the line as a BEATS-long burst of BURST_BITS
// beats, assembles it in place and returns it with a one-cycle pmem_resp.
// Optional: ICACHE_FILL_BUF_EN keeps tag+valid over the last completed line
// so a repeat request for that line answers without a burst.
module p_i_cache_line_fill #(
  parameter int LINE_BITS  = 256,
  parameter int BURST_BITS = 64,
  parameter int ADDR_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic [ADDR_BITS-1:0]  pmem_address,
  output logic [LINE_BITS-1:0]  pmem_rdata,
  output logic                  pmem_resp,
  output logic                  bmem_read,
  output logic [ADDR_BITS-1:0]  bmem_address,
  input  logic [BURST_BITS-1:0] bmem_rdata,
  input  logic                  bmem_resp
);
  localparam int BEATS = LINE_BITS / BURST_BITS;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_BITS / 8);

  typedef enum logic [1:0] {IDLE, FILL, RESP, GAP} state_t;

  state_t                               state_q, state_d;
  logic [CNT_W-1:0]                     beat_cnt;
  logic [ADDR_BITS-1:0]                 addr_q;
  logic [BEATS-1:0][BURST_BITS-1:0]     line_q;
  logic                                 last_beat, hit, accept;

  assign last_beat = bmem_resp && (beat_cnt == CNT_W'(BEATS - 1));
  // A fresh burst starts only on a request that the line buffer cannot serve.
  assign accept    = (state_q == IDLE) && pmem_read && !hit;

`ifdef ICACHE_FILL_BUF_EN
  logic buf_vld;
  // addr_q only moves on a miss, so it doubles as the tag of the held line.
  assign hit = buf_vld &&
               (addr_q[ADDR_BITS-1:OFF_W] == pmem_address[ADDR_BITS-1:OFF_W]);

  // Valid once a line has been returned; dropped as soon as a refill starts
  // since the slots are then overwritten in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 buf_vld <= 1'b0;
    else if (accept)          buf_vld <= 1'b0;
    else if (state_q == RESP) buf_vld <= 1'b1;
  end
`else
  assign hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and control outputs; GAP swallows the still-high request
  // the requester holds for the cycle after pmem_resp.
  always_comb begin
    state_d   = state_q;
    bmem_read = 1'b0;
    pmem_resp = 1'b0;
    case (state_q)
      IDLE: if (pmem_read) state_d = hit ? RESP : FILL;
      FILL: begin
        bmem_read = 1'b1;
        if (last_beat) state_d = RESP;
      end
      RESP: begin
        pmem_resp = 1'b1;
        state_d   = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line-aligned burst address, held for the whole burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        addr_q <= '0;
    else if (accept) addr_q <= {pmem_address[ADDR_BITS-1:OFF_W], {OFF_W{1'b0}}};
  end

  // Beat capture: only in FILL, slot chosen by beat_cnt, which wraps back to
  // zero on the last beat so every fill starts at slot 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      line_q   <= '0;
    end else if (state_q == FILL && bmem_resp) begin
      line_q[beat_cnt] <= bmem_rdata;
      beat_cnt         <= beat_cnt + 1'b1;
    end
  end

  assign pmem_rdata   = line_q;
  assign bmem_address = addr_q;
endmodule
